rr_burst_arbiter: RTL and testbench
===================================

RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

Interface
REQ-001 SHALL have parameter D_WIDTH, default 6, data width of all streams.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive beats per grant; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port a_data, input, D_WIDTH, requester A payload.
REQ-006 SHALL have port a_valid, input, 1, requester A beat present.
REQ-007 SHALL have port a_ready, output, 1, A beat accepted when a_valid and a_ready are both high at an edge.
REQ-008 SHALL have ports b_data, b_valid and b_ready, with the same widths and meanings for requester B.
REQ-009 SHALL have port down_data, output, D_WIDTH, registered merged payload; it feeds the two-stage FIFO chain.
REQ-010 SHALL have port down_valid, output, 1, registered; down_data is valid.
REQ-011 SHALL have port down_ready, input, 1, downstream accepts the beat.
REQ-012 SHALL have port down_src, output, 1, registered; source of the held beat (0 = A, 1 = B).

Function
REQ-013 SHALL use one output register stage with load_en = !down_valid || down_ready.
REQ-014 SHALL never deassert down_valid, or change down_data or down_src, while down_valid=1 and down_ready=0.
REQ-015 SHALL implement a state machine with states IDLE, GNT_A and GNT_B.
REQ-016 SHALL drive a_ready = (state==GNT_A) && load_en, and b_ready = (state==GNT_B) && load_en; both are 0 in IDLE.
- Ready has no combinational dependence on a_valid or b_valid.
REQ-017 On an accepted beat, SHALL load down_data from the granted requester, set down_valid=1 and set down_src = granted id.
REQ-018 When load_en=1 and no beat is accepted, SHALL clear down_valid to 0.
REQ-019 IDLE transitions:
- a_valid && b_valid -> grant the requester that is not `last`.
- Only one valid -> grant that requester.
- Neither valid -> stay in IDLE.
- This costs exactly one arbitration cycle before the first beat.
REQ-020 On entering GNT_x, SHALL set last = x and burst_cnt = 0.
REQ-021 SHALL increment burst_cnt on each accepted beat in GNT_x; the counter is at least clog2(MAX_BURST+1) bits and never wraps.
REQ-022 Burst end is a beat accepted while burst_cnt == MAX_BURST-1. At burst end:
- Other requester valid -> move to GNT_other.
- Else own valid -> stay in GNT_x with burst_cnt = 0.
- Else -> IDLE.
REQ-023 In GNT_x, a cycle with x_valid=0 SHALL leave the grant:
- Other requester valid -> GNT_other.
- Else -> IDLE.
- Regardless of load_en.
REQ-024 When MAX_BURST=1, SHALL alternate grants on every accepted beat whenever both requesters are valid.
REQ-025 SHALL guarantee that no requester waits more than MAX_BURST accepted beats of the other requester plus 1 cycle once its valid is high.
REQ-026 SHALL preserve order within each source stream; beats SHALL never be dropped or duplicated.

Reset
REQ-027 On rst low, SHALL asynchronously force: state=IDLE, burst_cnt=0, last=B, down_valid=0, down_data=0, down_src=0.
- Consequently a_ready=0 and b_ready=0.
REQ-028 When rst is asserted mid-burst, SHALL discard any held beat, and A SHALL win the first tie after release.
REQ-029 SHALL sample no inputs before the first rising clk edge after rst deasserts.

Verification
REQ-030 Reset check: hold rst low, toggle inputs -> down_valid=0, a_ready=b_ready=0, down_data=0.
REQ-031 Contention, MAX_BURST=4, down_ready=1: A sends 0x01..0x08 and B sends 0x21..0x28, both valid from t0.
- Output order SHALL be A:01-04, B:21-24, A:05-08, B:25-28.
- down_src sequence SHALL be 0000 1111 0000 1111.
REQ-032 Backpressure: down_ready=0 for 5 cycles with down_valid=1 -> down_data and down_src are stable and a_ready=b_ready=0; all beats are delivered after release.
REQ-033 Early release: only A valid for 2 beats, then a_valid=0 while b_valid=1 -> grant moves to B next cycle and burst_cnt restarts at 0.
REQ-034 Solo stream: only B valid for 10 beats with MAX_BURST=4 -> B keeps the grant, no IDLE bubble after the first, and 10 beats out back-to-back.
REQ-035 Mid-operation reset: assert rst during B's 3rd beat -> outputs cleared immediately; after release with both valid, A is granted first.

Source files
------------

// File: rtl/rr_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_burst_arbiter_if
// Description : Two requester streams and one merged downstream stream.
// Revision    : 1.0
// ============================================================================
interface rr_burst_arbiter_if #(
   parameter int D_WIDTH = 6
);
   logic [D_WIDTH-1:0] a_data;
   logic               a_valid;
   logic               a_ready;
   logic [D_WIDTH-1:0] b_data;
   logic               b_valid;
   logic               b_ready;
   logic [D_WIDTH-1:0] down_data;
   logic               down_valid;
   logic               down_ready;
   logic               down_src;

   modport master (
      output a_data, a_valid, b_data, b_valid, down_ready,
      input  a_ready, b_ready, down_data, down_valid, down_src
   );

   modport slave (
      input  a_data, a_valid, b_data, b_valid, down_ready,
      output a_ready, b_ready, down_data, down_valid, down_src
   );
endinterface
`default_nettype wire

// File: rtl/rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_burst_arbiter
// Description : Round-robin A/B merge with bounded bursts and a registered output.
// Revision    : 1.0
// ============================================================================
module rr_burst_arbiter #(
   parameter int D_WIDTH   = 6,
   parameter int MAX_BURST = 4
) (
   input wire                 clk,
   input wire                 rst,
   rr_burst_arbiter_if.slave  bus
);
   localparam int                 c_CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_CNT_W-1:0] r_burst_cnt;
   logic [c_CNT_W-1:0] w_burst_cnt_nxt;
   logic               r_last;
   logic               w_last_nxt;
   logic [D_WIDTH-1:0] r_down_data;
   logic               r_down_valid;
   logic               r_down_src;
   logic               w_load_en;
   logic               w_a_acc;
   logic               w_b_acc;
   logic               w_burst_end;

   assign w_load_en   = !r_down_valid || bus.down_ready;
   assign bus.a_ready = (r_state == GNT_A) && w_load_en;
   assign bus.b_ready = (r_state == GNT_B) && w_load_en;
   assign w_a_acc     = bus.a_valid && bus.a_ready;
   assign w_b_acc     = bus.b_valid && bus.b_ready;
   assign w_burst_end = (r_burst_cnt == c_LAST_BEAT);

   assign bus.down_data  = r_down_data;
   assign bus.down_valid = r_down_valid;
   assign bus.down_src   = r_down_src;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_burst_cnt <= '0;
         r_last      <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
         r_last      <= w_last_nxt;
      end
   end

   // r_last: 0 = A held the most recent grant, 1 = B.
   always_comb begin
      w_state_nxt     = r_state;
      w_burst_cnt_nxt = r_burst_cnt;
      w_last_nxt      = r_last;
      case (r_state)
         IDLE: begin
            if (bus.a_valid && bus.b_valid) begin
               w_state_nxt = r_last ? GNT_A : GNT_B;
            end else if (bus.a_valid) begin
               w_state_nxt = GNT_A;
            end else if (bus.b_valid) begin
               w_state_nxt = GNT_B;
            end
         end
         GNT_A: begin
            if (!bus.a_valid) begin
               w_state_nxt = bus.b_valid ? GNT_B : IDLE;
            end else if (w_a_acc) begin
               if (w_burst_end) begin
                  if (bus.b_valid) begin
                     w_state_nxt = GNT_B;
                  end else begin
                     w_burst_cnt_nxt = '0;
                  end
               end else begin
                  w_burst_cnt_nxt = r_burst_cnt + 1'b1;
               end
            end
         end
         GNT_B: begin
            if (!bus.b_valid) begin
               w_state_nxt = bus.a_valid ? GNT_A : IDLE;
            end else if (w_b_acc) begin
               if (w_burst_end) begin
                  if (bus.a_valid) begin
                     w_state_nxt = GNT_A;
                  end else begin
                     w_burst_cnt_nxt = '0;
                  end
               end else begin
                  w_burst_cnt_nxt = r_burst_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Any fresh grant restarts the burst and records its owner.
      if (w_state_nxt != r_state) begin
         if (w_state_nxt == GNT_A) begin
            w_last_nxt      = 1'b0;
            w_burst_cnt_nxt = '0;
         end else if (w_state_nxt == GNT_B) begin
            w_last_nxt      = 1'b1;
            w_burst_cnt_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_down_data  <= '0;
         r_down_valid <= 1'b0;
         r_down_src   <= 1'b0;
      end else if (w_load_en) begin
         if (w_a_acc) begin
            r_down_data  <= bus.a_data;
            r_down_valid <= 1'b1;
            r_down_src   <= 1'b0;
         end else if (w_b_acc) begin
            r_down_data  <= bus.b_data;
            r_down_valid <= 1'b1;
            r_down_src   <= 1'b1;
         end else begin
            r_down_valid <= 1'b0;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_burst_arbiter
// Description : Directed self-checking bench for rr_burst_arbiter (MAX_BURST=4).
// Revision    : 1.0
// ============================================================================
module tb_rr_burst_arbiter;
   localparam int c_DW = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [6:0] exp_q[$];
   logic [6:0] got_q[$];
   int         got_cyc[$];

   rr_burst_arbiter_if #(.D_WIDTH(c_DW)) bus();

   rr_burst_arbiter #(.D_WIDTH(c_DW), .MAX_BURST(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected beats as {src, data}; A payloads are 0x01+k, B payloads 0x21+k.
   task automatic add_a(input int first, input int n);
      for (int i = first; i < first + n; i++) exp_q.push_back({1'b0, 6'(8'h01 + i)});
   endtask

   task automatic add_b(input int first, input int n);
      for (int i = first; i < first + n; i++) exp_q.push_back({1'b1, 6'(8'h21 + i)});
   endtask

   task automatic run_stream(input int na, input int nb, input int pause_after,
                             input int pause_len, input int stall_from,
                             input int stall_len, input bit gapless);
      int         ia     = 0;
      int         ib     = 0;
      int         a_hold = 0;
      int         cyc    = 0;
      bit         fa;
      bit         fb;
      bit         stalled = 1'b0;
      logic [6:0] held    = '0;
      got_q.delete();
      got_cyc.delete();
      @(posedge clk); #1;
      bus.a_valid    = (ia < na) && (a_hold == 0);
      bus.a_data     = 6'(1 + ia);
      bus.b_valid    = (ib < nb);
      bus.b_data     = 6'(33 + ib);
      bus.down_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      while (got_q.size() < exp_q.size() && cyc < 200) begin
         @(negedge clk);
         fa = bus.a_valid && bus.a_ready;
         fb = bus.b_valid && bus.b_ready;
         if (stalled) begin
            check("stall_valid", bus.down_valid, 1);
            check("stall_hold", {bus.down_src, bus.down_data}, held);
         end
         stalled = bus.down_valid && !bus.down_ready;
         if (stalled) begin
            held = {bus.down_src, bus.down_data};
            check("stall_a_ready", bus.a_ready, 0);
            check("stall_b_ready", bus.b_ready, 0);
         end
         if (bus.down_valid && bus.down_ready) begin
            got_q.push_back({bus.down_src, bus.down_data});
            got_cyc.push_back(cyc);
         end
         @(posedge clk); #1;
         if (fa) begin
            ia++;
            if (ia == pause_after) a_hold = pause_len;
         end else if (a_hold > 0) begin
            a_hold--;
         end
         if (fb) ib++;
         cyc++;
         bus.a_valid    = (ia < na) && (a_hold == 0);
         bus.a_data     = 6'(1 + ia);
         bus.b_valid    = (ib < nb);
         bus.b_data     = 6'(33 + ib);
         bus.down_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      end
      check("beat_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("beat[%0d]", i), got_q[i], exp_q[i]);
      if (got_cyc.size() > 0) check("first_latency", got_cyc[0], 2);
      if (gapless)
         for (int i = 0; i < got_cyc.size(); i++)
            check($sformatf("gapless[%0d]", i), got_cyc[i], 2 + i);
      bus.a_valid    = 1'b0;
      bus.b_valid    = 1'b0;
      bus.down_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.a_data     = '0;
      bus.a_valid    = 1'b0;
      bus.b_data     = '0;
      bus.b_valid    = 1'b0;
      bus.down_ready = 1'b1;

      // Reset held low while inputs toggle.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.a_valid = ~bus.a_valid;
         bus.b_valid = 1'b1;
         bus.a_data  = 6'(5 + i);
         bus.b_data  = 6'(40 + i);
         @(posedge clk); #1;
         check("rst_down_valid", bus.down_valid, 0);
         check("rst_a_ready", bus.a_ready, 0);
         check("rst_b_ready", bus.b_ready, 0);
         check("rst_down_data", bus.down_data, 0);
         check("rst_down_src", bus.down_src, 0);
      end
      @(negedge clk);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      rst = 1'b1;

      // Contention: A wins the first tie, bursts of four alternate.
      exp_q.delete();
      add_a(0, 4); add_b(0, 4); add_a(4, 4); add_b(4, 4);
      run_stream(8, 8, -1, 0, -1, 0, 1'b1);

      // Backpressure: five stalled cycles while A02 is held.
      exp_q.delete();
      add_a(0, 4); add_b(0, 4);
      run_stream(4, 4, -1, 0, 3, 5, 1'b0);

      // Early release: A drops after two beats, B takes a fresh full burst.
      exp_q.delete();
      add_a(0, 2); add_b(0, 4); add_a(2, 4); add_b(4, 2);
      run_stream(6, 6, 2, 3, -1, 0, 1'b0);
      if (got_cyc.size() > 2) check("release_b_cycle", got_cyc[2], 5);

      // Solo B stream keeps its grant across burst boundaries.
      exp_q.delete();
      add_b(0, 10);
      run_stream(0, 10, -1, 0, -1, 0, 1'b1);

      // Reset while B's third beat is held.
      @(posedge clk); #1;
      bus.b_valid = 1'b1;
      bus.b_data  = 6'h23;
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_valid", bus.down_valid, 1);
      check("pre_rst_src", bus.down_src, 1);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", bus.down_valid, 0);
      check("mid_rst_data", bus.down_data, 0);
      check("mid_rst_src", bus.down_src, 0);
      check("mid_rst_b_ready", bus.b_ready, 0);
      bus.a_valid = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_a_ready", bus.a_ready, 0);
      check("mid_rst_valid2", bus.down_valid, 0);
      @(negedge clk);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      add_a(0, 4); add_b(0, 4);
      run_stream(4, 4, -1, 0, -1, 0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
